// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run-control front end: debounced continue button, halt/step FSM,
// halt cause and saturating halt count feeding the pipeline stop latch.
module run_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_raw_i,
  input  logic             step_mode_i,
  input  logic             syscall_halt_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  input  logic [31:0]      pc_i,
  input  logic             stopped_i,
  output logic             stop_g_o,
  output logic             continue_o,
  output logic [1:0]       cause_o,
  output logic [CNT_W-1:0] halt_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALT   = 2'd1,
    S_RESUME = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_SYSCALL = 2'b01;
  localparam logic [1:0] CAUSE_BP      = 2'b10;
  localparam logic [1:0] CAUSE_STEP    = 2'b11;

  logic             sync1_q, sync2_q;
  logic             deb_q, press_q;
  logic [19:0]      deb_cnt_q;

  state_t           state_q;
  logic             stop_g_q, continue_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;
  logic             bp_armed_q, bp_halt_q;
  logic             bp_hit, halt_ev;

  // Synchronizer plus stability counter; press_q marks the accepted 0->1 edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_CYCLES - 20'd1) begin
        deb_cnt_q <= '0;
        deb_q     <= sync2_q;
        press_q   <= sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + 20'd1;
      end
    end
  end

  always_comb begin
    halt_cnt_d = (&halt_cnt_q) ? halt_cnt_q : halt_cnt_q + CNT_W'(1);
    bp_hit     = bp_en_i & bp_armed_q & (pc_i == bp_addr_i);
    halt_ev    = syscall_halt_i | bp_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RUN;
      stop_g_q   <= 1'b0;
      continue_q <= 1'b0;
      cause_q    <= 2'b00;
      halt_cnt_q <= '0;
      bp_armed_q <= 1'b1;
      bp_halt_q  <= 1'b0;
    end else begin
      stop_g_q   <= 1'b0;
      continue_q <= 1'b0;
      if (pc_i != bp_addr_i) bp_armed_q <= 1'b1;
      case (state_q)
        S_RUN: begin
          if (halt_ev && !stopped_i) begin
            stop_g_q   <= 1'b1;
            cause_q    <= syscall_halt_i ? CAUSE_SYSCALL : CAUSE_BP;
            halt_cnt_q <= halt_cnt_d;
            bp_halt_q  <= ~syscall_halt_i;
            state_q    <= S_HALT;
          end
        end
        S_HALT: begin
          if (press_q) begin
            continue_q <= 1'b1;
            state_q    <= S_RESUME;
          end
        end
        S_RESUME: begin
          // Disarm so resuming at the breakpoint PC does not immediately re-halt.
          if (bp_halt_q) bp_armed_q <= 1'b0;
          if (step_mode_i) begin
            stop_g_q   <= 1'b1;
            cause_q    <= CAUSE_STEP;
            halt_cnt_q <= halt_cnt_d;
            bp_halt_q  <= 1'b0;
            state_q    <= S_STEP;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_STEP: state_q <= S_HALT;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign stop_g_o   = stop_g_q;
  assign continue_o = continue_q;
  assign cause_o    = cause_q;
  assign halt_cnt_o = halt_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed bench for run_ctrl with an event scoreboard and
// a narrow-counter second instance for saturation.
`timescale 1ns/1ps
module tb_run_ctrl;
  localparam int DEB_N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b0, step_mode = 1'b0, syscall = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0, pc = 32'h0040_0000;
  logic        stopped;
  logic        stop_g, cont, s_stop_g, s_cont;
  logic [1:0]  cause, s_cause;
  logic [15:0] cnt;
  logic [1:0]  s_cnt;

  run_ctrl #(.DEB_CYCLES(20'd4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(btn), .step_mode_i(step_mode),
    .syscall_halt_i(syscall), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .stopped_i(stopped), .stop_g_o(stop_g), .continue_o(cont), .cause_o(cause),
    .halt_cnt_o(cnt));

  run_ctrl #(.DEB_CYCLES(20'd4), .CNT_W(2)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(btn), .step_mode_i(step_mode),
    .syscall_halt_i(syscall), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .stopped_i(stopped), .stop_g_o(s_stop_g), .continue_o(s_cont), .cause_o(s_cause),
    .halt_cnt_o(s_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stop latch stand-in: set by stop_g, cleared by continue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stopped <= 1'b0;
    else if (stop_g) stopped <= 1'b1;
    else if (cont)   stopped <= 1'b0;
  end

  typedef struct {
    bit          is_stop;
    int          at;
    logic [1:0]  cause;
    logic [15:0] cnt;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          fails = 0;
  logic [1:0]  m_cause = 2'b00;
  logic [15:0] m_cnt = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_stop(input int at, input logic [1:0] c);
    m_cause = c;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    exp_q.push_back('{is_stop: 1'b1, at: at, cause: c, cnt: m_cnt});
  endtask

  task automatic exp_cont(input int at);
    exp_q.push_back('{is_stop: 1'b0, at: at, cause: m_cause, cnt: m_cnt});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit step);
    int c;
    @(negedge clk);
    btn = 1'b1;
    c = cyc;
    exp_cont(c + DEB_N + 3);
    if (step) exp_stop(c + DEB_N + 4, 2'b11);
    tick(12);
    btn = 1'b0;
    tick(10);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stop"}, stop_g, 0);
    check({tag, "_cont"}, cont, 0);
    check({tag, "_cause"}, cause, 0);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_scnt"}, s_cnt, 0);
  endtask

  always @(negedge clk) begin : monitor
    ev_t        e;
    logic [1:0] s_exp;
    if (rst_n && (stop_g || cont)) begin
      check("stop_cont_exclusive", stop_g & cont, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {stop_g, cont}, 0);
      end else begin
        e = exp_q.pop_front();
        s_exp = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
        check("ev_kind", stop_g, e.is_stop);
        check("ev_cycle", cyc, e.at);
        check("ev_cause", cause, e.cause);
        check("ev_cnt", cnt, e.cnt);
        check("ev_small_cnt", s_cnt, s_exp);
        check("ev_small_outs", {s_stop_g, s_cont, s_cause}, {stop_g, cont, cause});
      end
    end
  end

  initial begin
    int c;
    tick(2);
    check_idle("reset");

    // Reset mid-debounce, then a press while running is discarded.
    rst_n = 1'b1;
    tick(2);
    btn = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_mid_deb");
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    btn = 1'b0;
    tick(10);
    check_idle("run_press_ignored");

    // Syscall halt, then a bouncy press.
    @(negedge clk);
    syscall = 1'b1;
    exp_stop(cyc + 1, 2'b01);
    tick(1);
    syscall = 1'b0;
    tick(3);
    check("t2_cause", cause, 2'b01);
    check("t2_cnt", cnt, 1);
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(1);
    btn = 1'b1;
    exp_cont(cyc + DEB_N + 3);
    tick(12);
    btn = 1'b0;
    tick(10);

    // Breakpoint halt, resume at the same PC, re-halt on the next visit.
    bp_en = 1'b1;
    bp_addr = 32'h0040_0010;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h0040_0000 + 32'(i * 4);
      tick(1);
    end
    pc = 32'h0040_0010;
    exp_stop(cyc + 1, 2'b10);
    tick(3);
    check("t3_cause", cause, 2'b10);
    press(1'b0);
    tick(10);
    pc = 32'h0040_0014;
    tick(1);
    pc = 32'h0040_0010;
    exp_stop(cyc + 1, 2'b10);
    tick(3);
    check("t3_cnt", cnt, 3);

    // Single-step: three presses, three step halts.
    step_mode = 1'b1;
    repeat (3) press(1'b1);
    check("t4_cause", cause, 2'b11);
    check("t4_cnt", cnt, 6);
    step_mode = 1'b0;
    press(1'b0);
    tick(5);
    pc = 32'h0040_0020;
    tick(2);

    // Syscall and breakpoint together: syscall cause, one count.
    pc = 32'h0040_0010;
    syscall = 1'b1;
    exp_stop(cyc + 1, 2'b01);
    tick(1);
    syscall = 1'b0;
    pc = 32'h0040_0020;
    tick(3);
    check("t5_cause", cause, 2'b01);
    check("t5_cnt", cnt, 7);
    press(1'b0);

    // Narrow counter stays saturated while stop_g still pulses.
    syscall = 1'b1;
    exp_stop(cyc + 1, 2'b01);
    tick(1);
    syscall = 1'b0;
    tick(3);
    check("t6_sat", s_cnt, 2'd3);
    check("t6_cnt", cnt, 8);

    // Asynchronous reset while halted with nonzero cause and count.
    #2 rst_n = 1'b0;
    #1 check_idle("rst_in_halt");
    m_cnt = 16'h0;
    m_cause = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    syscall = 1'b1;
    exp_stop(cyc + 1, 2'b01);
    tick(1);
    syscall = 1'b0;
    tick(3);
    check("post_rst_cnt", cnt, 1);
    check("pending_events", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
